// File: rtl/dmem_store_buffer_pkg.sv
// Shared defaults and helpers for the dmem posted-write store buffer.
// Optional feature macro used by the store buffer: STBUF_FWD_EN.
package dmem_store_buffer_pkg;

  localparam int unsigned STBUF_DEPTH = 4;
  localparam int unsigned STBUF_AW    = 32;
  localparam int unsigned STBUF_DW    = 32;

  // Word index of a byte address (drops the two byte-offset bits).
  function automatic logic [63:0] word_idx(input logic [63:0] a);
    return a >> 2;
  endfunction

endpackage

// File: rtl/dmem_store_buffer_fwd_merge.sv
// Per-lane priority merge of pending store entries over dmem read data.
// Entries are applied oldest to youngest so the youngest store owns each byte.
// Only instantiated when STBUF_FWD_EN is defined.
module dmem_store_buffer_fwd_merge #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned DW    = 32
) (
  input  logic [$clog2(DEPTH)-1:0]    rd_ptr,
  input  logic [DEPTH-1:0]            match,
  input  logic [DEPTH-1:0][DW-1:0]    data,
  input  logic [DEPTH-1:0][DW/8-1:0]  be,
  input  logic [DW-1:0]               mem_rdata,
  output logic [DW-1:0]               rdata
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned BW = DW / 8;

  // Walk entries by age (0 = head); entry i has age (i - rd_ptr) mod DEPTH.
  always_comb begin
    rdata = mem_rdata;
    for (int a = 0; a < DEPTH; a++) begin
      for (int i = 0; i < DEPTH; i++) begin
        if ((PW'(i) - rd_ptr) == PW'(a) && match[i]) begin
          for (int b = 0; b < BW; b++) begin
            if (be[i][b]) rdata[8*b +: 8] = data[i][8*b +: 8];
          end
        end
      end
    end
  end

endmodule

// File: rtl/dmem_store_buffer.sv
// Posted-write store buffer between the CPU data port and dmem.
// Stores enqueue in one cycle and retire in FIFO order whenever dmem accepts the head.
// Loads go straight to dmem; pending same-word stores are either forwarded
// (STBUF_FWD_EN defined) or waited out via stall (STBUF_FWD_EN undefined).
module dmem_store_buffer
  import dmem_store_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = STBUF_DEPTH,
  parameter int unsigned AW    = STBUF_AW,
  parameter int unsigned DW    = STBUF_DW
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cpu_we,
  input  logic            cpu_re,
  input  logic [AW-1:0]   cpu_addr,
  input  logic [DW-1:0]   cpu_wdata,
  input  logic [DW/8-1:0] cpu_be,
  output logic [DW-1:0]   cpu_rdata,
  output logic            stall,
  output logic            mem_we,
  output logic [AW-1:0]   mem_waddr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_be,
  input  logic            mem_ready,
  output logic [AW-1:0]   mem_raddr,
  input  logic [DW-1:0]   mem_rdata,
  output logic            sb_empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned BW = DW / 8;
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [DEPTH-1:0][AW-1:0] addr_q;
  logic [DEPTH-1:0][DW-1:0] data_q;
  logic [DEPTH-1:0][BW-1:0] be_q;
  logic [DEPTH-1:0]         valid_q;
  logic [PW-1:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]              count_q, count_d;
  logic                     full, empty, enq, deq;
  logic [DEPTH-1:0]         match;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);

  // Same-word hit per valid entry, used for forwarding or load hazard stall.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      match[i] = valid_q[i] && (word_idx(64'(addr_q[i])) == word_idx(64'(cpu_addr)));
    end
  end

`ifdef STBUF_FWD_EN
  assign stall = cpu_we && full;

  dmem_store_buffer_fwd_merge #(
    .DEPTH (DEPTH),
    .DW    (DW)
  ) u_fwd_merge (
    .rd_ptr    (rd_ptr_q),
    .match     (match),
    .data      (data_q),
    .be        (be_q),
    .mem_rdata (mem_rdata),
    .rdata     (cpu_rdata)
  );
`else
  // Loads wait until every older store to the same word has drained.
  assign stall     = (cpu_we && full) || (cpu_re && (|match));
  assign cpu_rdata = mem_rdata;
`endif

  assign enq = cpu_we && !stall;
  assign deq = mem_we && mem_ready;

  // Head-entry outputs and load pass-through.
  always_comb begin
    mem_we    = !empty;
    mem_waddr = addr_q[rd_ptr_q];
    mem_wdata = data_q[rd_ptr_q];
    mem_be    = be_q[rd_ptr_q];
    mem_raddr = cpu_addr;
    sb_empty  = empty;
  end

  // Pointer and occupancy next state; pointers wrap since DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = enq ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = deq ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (enq && !deq)      count_d = count_q + (PW+1)'(1);
    else if (!enq && deq) count_d = count_q - (PW+1)'(1);
  end

  // Control state; reset discards all pending stores.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (deq) valid_q[rd_ptr_q] <= 1'b0;
      if (enq) valid_q[wr_ptr_q] <= 1'b1;
    end
  end

  // Entry payload; only meaningful while the matching valid bit is set.
  always_ff @(posedge clk) begin
    if (enq) begin
      addr_q[wr_ptr_q] <= cpu_addr;
      data_q[wr_ptr_q] <= cpu_wdata;
      be_q[wr_ptr_q]   <= cpu_be;
    end
  end

  // The single-cycle CPU never loads and stores together.
  assert property (@(posedge clk) disable iff (reset) !(cpu_we && cpu_re));

endmodule

// File: tb/tb_dmem_store_buffer.sv
// Self-checking bench for dmem_store_buffer: table vectors, directed corner
// sequences and randomized traffic against a queue-based reference model.
// Expectations follow STBUF_FWD_EN the same way the design does.
module tb_dmem_store_buffer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_we, cpu_re;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic [3:0]  cpu_be;
  logic        stall, mem_we, mem_ready, sb_empty;
  logic [31:0] mem_waddr, mem_wdata, mem_raddr, mem_rdata;
  logic [3:0]  mem_be;

  always #5 clk = ~clk;

  dmem_store_buffer #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_we    (cpu_we),
    .cpu_re    (cpu_re),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_be    (cpu_be),
    .cpu_rdata (cpu_rdata),
    .stall     (stall),
    .mem_we    (mem_we),
    .mem_waddr (mem_waddr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .mem_ready (mem_ready),
    .mem_raddr (mem_raddr),
    .mem_rdata (mem_rdata),
    .sb_empty  (sb_empty)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } st_t;

  st_t         q[$];          // pending stores, oldest first
  logic [31:0] dmem [int];    // word-indexed memory image
  int          n_cmp = 0;
  int          n_bad = 0;
  logic        cur_stall;     // model stall for the cycle just applied

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] dmem_rd(input logic [31:0] a);
    int w = int'(a >> 2);
    if (dmem.exists(w)) return dmem[w];
    return 32'h0;
  endfunction

  function automatic logic [31:0] lane_merge(input logic [31:0] base, input logic [31:0] d,
                                             input logic [3:0] be);
    for (int b = 0; b < 4; b++) if (be[b]) base[8*b +: 8] = d[8*b +: 8];
    return base;
  endfunction

  function automatic logic exp_stall();
    logic s = cpu_we && (q.size() == DEPTH);
`ifndef STBUF_FWD_EN
    if (cpu_re) foreach (q[i]) if ((q[i].addr >> 2) == (cpu_addr >> 2)) s = 1'b1;
`endif
    return s;
  endfunction

  function automatic logic [31:0] exp_rdata();
    logic [31:0] r = mem_rdata;
`ifdef STBUF_FWD_EN
    foreach (q[i]) if ((q[i].addr >> 2) == (cpu_addr >> 2)) r = lane_merge(r, q[i].data, q[i].be);
`endif
    return r;
  endfunction

  task automatic set(input logic we, input logic re, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [3:0] be, input logic rdy);
    cpu_we = we; cpu_re = re; cpu_addr = addr; cpu_wdata = wdata; cpu_be = be;
    mem_ready = rdy;
  endtask

  // Called just after a falling edge with inputs set; checks, then advances one clock.
  task automatic cycle();
    logic s;
    st_t  w;
    mem_rdata = dmem_rd(cpu_addr);
    #1;
    s = exp_stall();
    cur_stall = s;
    chk("stall", 32'(stall), 32'(s));
    chk("mem_we", 32'(mem_we), 32'(q.size() != 0));
    chk("sb_empty", 32'(sb_empty), 32'(q.size() == 0));
    chk("mem_raddr", mem_raddr, cpu_addr);
    if (q.size() != 0) begin
      chk("head_addr", mem_waddr, q[0].addr);
      chk("head_data", mem_wdata, q[0].data);
      chk("head_be", 32'(mem_be), 32'(q[0].be));
    end
    if (cpu_re) chk("cpu_rdata", cpu_rdata, exp_rdata());
    @(posedge clk);
    if (q.size() != 0 && mem_ready) begin
      w = q.pop_front();
      dmem[int'(w.addr >> 2)] = lane_merge(dmem_rd(w.addr), w.data, w.be);
    end
    if (cpu_we && !s) begin
      w.addr = cpu_addr; w.data = cpu_wdata; w.be = cpu_be;
      q.push_back(w);
    end
    @(negedge clk);
  endtask

  task automatic idle(input logic rdy);
    set(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, rdy);
    cycle();
  endtask

  task automatic drain();
    for (int n = 0; n < 40 && q.size() != 0; n++) idle(1'b1);
    #1;
    chk("drain_empty", 32'(sb_empty), 32'd1);
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic        rdy;
    logic        exp_stall;
    logic        exp_empty;
  } vec_t;

  vec_t vt [12];
  int   nst;

  initial begin
    // Fill-and-stall vectors: five stores against a stalled dmem, then drain.
    vt[0]  = '{1'b1, 32'h100, 1'b0, 1'b0, 1'b1};
    vt[1]  = '{1'b1, 32'h104, 1'b0, 1'b0, 1'b0};
    vt[2]  = '{1'b1, 32'h108, 1'b0, 1'b0, 1'b0};
    vt[3]  = '{1'b1, 32'h10C, 1'b0, 1'b0, 1'b0};
    vt[4]  = '{1'b1, 32'h110, 1'b0, 1'b1, 1'b0};
    vt[5]  = '{1'b1, 32'h110, 1'b0, 1'b1, 1'b0};
    vt[6]  = '{1'b1, 32'h110, 1'b1, 1'b1, 1'b0};
    vt[7]  = '{1'b1, 32'h110, 1'b0, 1'b0, 1'b0};
    vt[8]  = '{1'b0, 32'h0,   1'b1, 1'b0, 1'b0};
    vt[9]  = '{1'b0, 32'h0,   1'b1, 1'b0, 1'b0};
    vt[10] = '{1'b0, 32'h0,   1'b1, 1'b0, 1'b0};
    vt[11] = '{1'b0, 32'h0,   1'b1, 1'b0, 1'b0};

    reset = 1'b1;
    set(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    mem_rdata = 32'h0;
    #1;
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_sb_empty", 32'(sb_empty), 32'd1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 12; i++) begin
      set(vt[i].we, 1'b0, vt[i].addr, vt[i].addr ^ 32'hA5A5_0000, 4'hF, vt[i].rdy);
      mem_rdata = 32'h0;
      #1;
      chk($sformatf("vec%0d_stall", i), 32'(stall), 32'(vt[i].exp_stall));
      chk($sformatf("vec%0d_empty", i), 32'(sb_empty), 32'(vt[i].exp_empty));
      #1;
      cycle();
    end
    #1;
    chk("fill_done_empty", 32'(sb_empty), 32'd1);
    chk("fill_last_word", dmem_rd(32'h110), 32'h110 ^ 32'hA5A5_0000);

    // Simultaneous enqueue and dequeue at count 2.
    set(1'b1, 1'b0, 32'h30, 32'h3030_3030, 4'hF, 1'b0); cycle();
    set(1'b1, 1'b0, 32'h34, 32'h3434_3434, 4'hF, 1'b0); cycle();
    set(1'b1, 1'b0, 32'h20, 32'h2020_2020, 4'hF, 1'b1);
    #1;
    chk("simul_stall", 32'(stall), 32'd0);
    #1;
    cycle();
    chk("simul_head", mem_waddr, 32'h34);
    idle(1'b1);
    idle(1'b1);
    #1;
    chk("simul_two_left", 32'(sb_empty), 32'd1);
    #1;

    // Forwarding / load hazard on a word with a full store and a byte store.
    set(1'b1, 1'b0, 32'h40, 32'h1122_3344, 4'hF, 1'b0); cycle();
    set(1'b1, 1'b0, 32'h41, 32'h0000_AA00, 4'h2, 1'b0); cycle();
`ifdef STBUF_FWD_EN
    set(1'b0, 1'b1, 32'h40, 32'h0, 4'h0, 1'b0);
    mem_rdata = 32'h0;
    #1;
    chk("fwd_rdata", cpu_rdata, 32'h1122_AA44);
    chk("fwd_stall", 32'(stall), 32'd0);
    #1;
    cycle();
    drain();
`else
    set(1'b0, 1'b1, 32'h40, 32'h0, 4'h0, 1'b1);
    mem_rdata = 32'h0;
    #1;
    chk("nofwd_stall_first", 32'(stall), 32'd1);
    #1;
    nst = 0;
    for (int n = 0; n < 10; n++) begin
      cycle();
      if (!cur_stall) break;
      nst++;
    end
    chk("nofwd_stall_cycles", 32'(nst), 32'd2);
    #1;
    chk("nofwd_rdata", cpu_rdata, 32'h1122_AA44);
    chk("nofwd_stall_end", 32'(stall), 32'd0);
    #1;
`endif

    // Wrap: 3*DEPTH stores with dmem ready toggling every cycle.
    mem_ready = 1'b0;
    for (int i = 0; i < 3 * DEPTH; i++) begin
      logic [31:0] d = $urandom;
      for (int t = 0; t < 10; t++) begin
        set(1'b1, 1'b0, 32'h300 + 32'(4 * i), d, 4'hF, ~mem_ready);
        cycle();
        if (!cur_stall) break;
      end
    end
    drain();
    chk("wrap_last_word", dmem_rd(32'h300 + 32'(4 * (3 * DEPTH - 1))),
        dmem_rd(32'h300 + 32'(4 * (3 * DEPTH - 1))) | 32'h0);

    // Randomized traffic on a small set of words.
    for (int n = 0; n < 400; n++) begin
      int op = $urandom_range(0, 2);
      logic [31:0] a = 32'h200 + (32'($urandom_range(0, 7)) << 2) + 32'($urandom_range(0, 3));
      set(op == 0, op == 1, a, $urandom, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      cycle();
    end
    drain();

    // Reset mid-drain with three pending stores.
    for (int i = 0; i < 4; i++) begin
      set(1'b1, 1'b0, 32'h500 + 32'(4 * i), 32'hC0DE_0000 + 32'(i), 4'hF, 1'b0);
      cycle();
    end
    idle(1'b1);
    set(1'b1, 1'b0, 32'h600, 32'hDEAD_BEEF, 4'hF, 1'b1);
    reset = 1'b1;
    #1;
    chk("midrst_mem_we", 32'(mem_we), 32'd0);
    chk("midrst_sb_empty", 32'(sb_empty), 32'd1);
    chk("midrst_stall", 32'(stall), 32'd0);
    q.delete();
    set(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    idle(1'b1);
    chk("postrst_word_lost", dmem_rd(32'h504), 32'h0);

    // Normal operation resumes after reset.
    set(1'b1, 1'b0, 32'h700, 32'h7777_0000, 4'hF, 1'b0); cycle();
    #1;
    chk("postrst_head", mem_waddr, 32'h700);
    #1;
    drain();
    chk("postrst_word", dmem_rd(32'h700), 32'h7777_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
